ex_mem_branch_stage: RTL and testbench
======================================

Name: ex_mem_branch_stage

Overview:
- Pipeline register directly downstream of the 64-bit ALU. Captures ALU Result/ZERO plus forwarded operands and control into the EX/MEM boundary.
- Resolves conditional branches from ZERO, computes the branch target, drives the PC redirect and squashes wrong-path instructions still in flight behind a taken branch.
- Feeds the data-memory stage and the PC mux.

Parameters:
- XLEN, 64, datapath width (Result, PC, immediate, store data).
- SQUASH_DEPTH, 2, number of younger accepted instructions converted to bubbles after a taken branch (IF/ID + ID/EX).
- CNT_W, 32, width of taken-branch statistics counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX stage holds a real instruction
- stall  in  1  hold all state (memory stage busy)
- flush  in  1  synchronous kill of stage contents and squash state
- alu_result  in  XLEN  ALU Result
- alu_zero  in  1  ALU ZERO (branch condition already selected by func_3)
- pc_in  in  XLEN  PC of EX instruction
- imm_in  in  XLEN  sign-extended B-type immediate (byte offset / 2)
- rs2_data  in  XLEN  store data
- rd_in  in  5  destination register
- branch, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  control from decode
- out_valid  out  1  registered instruction valid
- result_q  out  XLEN  registered ALU Result (memory address / writeback value)
- store_data_q  out  XLEN  registered rs2_data
- rd_q  out  5  registered rd
- mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q  out  1 each  registered controls, gated by valid
- branch_target_q  out  XLEN  registered pc_in + (imm_in << 1), modulo 2^XLEN
- pc_src  out  1  redirect PC to branch_target_q
- squash_active  out  1  squash counter nonzero
- taken_cnt  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async, reset_n=0): every output 0, squash counter 0, taken_cnt 0. Release is synchronous to the next rising edge.
- Priority per edge: flush > stall > capture.
- Flush:
  - out_valid, pc_src, all *_q controls := 0; squash counter := 0.
  - Data fields don't care (hold allowed); taken_cnt unchanged.
- Stall (no flush): all registers, pc_src and squash counter hold; nothing decrements.
- Capture (neither asserted):
  - eff_valid = in_valid && (squash counter == 0).
  - If squash counter != 0, it decrements by 1 on every capture edge, regardless of in_valid.
  - out_valid := eff_valid. Data fields always load.
  - Control _q := control_in && eff_valid, so bubbles never write memory or registers.
  - taken = eff_valid && branch && alu_zero.
  - pc_src := taken.
  - If taken: squash counter := SQUASH_DEPTH; taken_cnt += 1, saturating at all-ones.
  - A taken branch arriving while squashing is itself squashed: no redirect, no count.
- pc_src is a level. It stays high while a stalled taken branch is held; the PC mux is idempotent.
- Latency: one cycle, inputs to *_q/pc_src. branch_target_q is valid in the same cycle as pc_src.
- Target arithmetic: the shift-left-1 and add wrap modulo 2^XLEN, with no overflow flag.
- squash_active = (squash counter != 0), registered state.
- Reset mid-squash clears the counter immediately. Flush mid-squash clears it on the edge.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0. Release, then in_valid=1, reg_write=1, alu_result=0x10, rd=5 -> next cycle out_valid=1, result_q=0x10, rd_q=5, reg_write_q=1, pc_src=0.
- Taken branch: in_valid=1, branch=1, alu_zero=1, pc_in=0x100, imm_in=0x8 -> pc_src=1, branch_target_q=0x110, taken_cnt=1, squash_active=1.
  - Next two valid reg_write instructions -> out_valid=0, reg_write_q=0.
  - Third -> out_valid=1.
- Not-taken branch: branch=1, alu_zero=0 -> pc_src=0, squash_active=0, taken_cnt unchanged, out_valid=1.
- Stall during squash: after a taken branch, assert stall for 3 cycles -> pc_src stays 1, counter holds at 2. Release -> exactly two squashed captures follow.
- Flush vs stall: flush=1 and stall=1 together with a taken branch held -> out_valid=0, pc_src=0, squash_active=0.
- Wrap and saturation: pc_in=0xFFFFFFFFFFFFFFF0, imm_in=0x10 -> branch_target_q=0x10. Preload taken_cnt near max (CNT_W=4 build), drive 20 taken branches -> taken_cnt sticks at 0xF.

Source files
------------

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch resolution.
// Captures the ALU result and forwarded operands, resolves conditional
// branches from ZERO, drives the PC redirect and turns the younger
// in-flight instructions behind a taken branch into bubbles.
module ex_mem_branch_stage #(
    parameter int XLEN         = 64,
    parameter int SQUASH_DEPTH = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [4:0]       rd_in,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    output logic             out_valid,
    output logic [XLEN-1:0]  result_q,
    output logic [XLEN-1:0]  store_data_q,
    output logic [4:0]       rd_q,
    output logic             mem_read_q,
    output logic             mem_write_q,
    output logic             mem_to_reg_q,
    output logic             reg_write_q,
    output logic [XLEN-1:0]  branch_target_q,
    output logic             pc_src,
    output logic             squash_active,
    output logic [CNT_W-1:0] taken_cnt
);

    // Counter must hold SQUASH_DEPTH; keep at least one bit.
    localparam int SQ_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_DEPTH);

    logic [SQ_W-1:0] sq_cnt;
    logic            eff_valid;
    logic            taken;
    logic [XLEN-1:0] target;

    // Qualify the incoming instruction and resolve the branch; target wraps.
    always_comb begin
        eff_valid = in_valid && (sq_cnt == '0);
        taken     = eff_valid && branch && alu_zero;
        target    = pc_in + (imm_in << 1);
    end

    // Control, valid, redirect and squash state: flush > stall > capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            pc_src       <= 1'b0;
            sq_cnt       <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            pc_src       <= 1'b0;
            sq_cnt       <= '0;
        end else if (!stall) begin
            out_valid    <= eff_valid;
            mem_read_q   <= mem_read   && eff_valid;
            mem_write_q  <= mem_write  && eff_valid;
            mem_to_reg_q <= mem_to_reg && eff_valid;
            reg_write_q  <= reg_write  && eff_valid;
            pc_src       <= taken;
            // A taken branch can only be seen with the counter at zero,
            // so reload and decrement never compete.
            if (taken)
                sq_cnt <= SQ_LOAD;
            else if (sq_cnt != '0)
                sq_cnt <= sq_cnt - 1'b1;
        end
    end

    // Data fields load on every capture edge and hold across flush/stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q        <= '0;
            store_data_q    <= '0;
            rd_q            <= '0;
            branch_target_q <= '0;
        end else if (!flush && !stall) begin
            result_q        <= alu_result;
            store_data_q    <= rs2_data;
            rd_q            <= rd_in;
            branch_target_q <= target;
        end
    end

    // Saturating taken-branch statistic; untouched by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            taken_cnt <= '0;
        else if (!flush && !stall && taken && (taken_cnt != '1))
            taken_cnt <= taken_cnt + 1'b1;
    end

    // Squash state is visible directly from the register.
    always_comb squash_active = (sq_cnt != '0);

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Scoreboard bench for ex_mem_branch_stage: the driver predicts each edge's
// outcome with a behavioural model, a monitor compares at the falling edge.
module tb_ex_mem_branch_stage;

    localparam int XLEN  = 64;
    localparam int SQD   = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid, stall, flush;
    logic [XLEN-1:0]  alu_result, pc_in, imm_in, rs2_data;
    logic             alu_zero;
    logic [4:0]       rd_in;
    logic             branch, mem_read, mem_write, mem_to_reg, reg_write;
    logic             out_valid;
    logic [XLEN-1:0]  result_q, store_data_q, branch_target_q;
    logic [4:0]       rd_q;
    logic             mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;
    logic             pc_src, squash_active;
    logic [CNT_W-1:0] taken_cnt;

    ex_mem_branch_stage #(.XLEN(XLEN), .SQUASH_DEPTH(SQD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_result(alu_result), .alu_zero(alu_zero), .pc_in(pc_in), .imm_in(imm_in),
        .rs2_data(rs2_data), .rd_in(rd_in), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .out_valid(out_valid), .result_q(result_q), .store_data_q(store_data_q),
        .rd_q(rd_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
        .mem_to_reg_q(mem_to_reg_q), .reg_write_q(reg_write_q),
        .branch_target_q(branch_target_q), .pc_src(pc_src),
        .squash_active(squash_active), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            ov;
        bit [XLEN-1:0] res, sd, tgt;
        bit [4:0]      rd;
        bit            mr, mw, mtr, rw, ps, sa;
        int            cnt;
        bit            known;   // data fields defined (not after flush)
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   sq_left;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: one pipeline-boundary step from the rules of the stage.
    task automatic model_step();
        bit ev, tk;
        if (!reset_n) begin
            m = '{default: 0};
            m.known = 1;
            sq_left = 0;
        end else if (flush) begin
            m.ov = 0; m.ps = 0; m.mr = 0; m.mw = 0; m.mtr = 0; m.rw = 0;
            sq_left = 0;
            m.known = 0;
        end else if (!stall) begin
            ev = in_valid && (sq_left == 0);
            if (sq_left > 0) sq_left--;
            tk = ev && branch && alu_zero;
            m.ov  = ev;
            m.res = alu_result;
            m.sd  = rs2_data;
            m.rd  = rd_in;
            m.tgt = pc_in + imm_in * 2;
            m.known = 1;
            m.mr  = mem_read && ev;
            m.mw  = mem_write && ev;
            m.mtr = mem_to_reg && ev;
            m.rw  = reg_write && ev;
            m.ps  = tk;
            if (tk) begin
                sq_left = SQD;
                if (m.cnt < CMAX) m.cnt++;
            end
        end
        m.sa = (sq_left != 0);
        q.push_back(m);
    endtask

    // One clock: inputs already set are sampled, expectation queued.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rnd_data();
        alu_result = {$urandom, $urandom};
        pc_in      = {$urandom, $urandom};
        imm_in     = {$urandom, $urandom};
        rs2_data   = {$urandom, $urandom};
        rd_in      = 5'($urandom);
        alu_zero   = 1'($urandom);
        {branch, mem_read, mem_write, mem_to_reg, reg_write} = 5'($urandom);
    endtask

    task automatic instr(bit v, bit br, bit z, bit rw, logic [XLEN-1:0] pc, logic [XLEN-1:0] imm);
        rnd_data();
        in_valid = v; branch = br; alu_zero = z; reg_write = rw;
        mem_read = 0; mem_write = 0; mem_to_reg = 0;
        pc_in = pc; imm_in = imm;
        stall = 0; flush = 0;
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_valid", out_valid, e.ov);
                chk("pc_src", pc_src, e.ps);
                chk("squash_active", squash_active, e.sa);
                chk("taken_cnt", taken_cnt, e.cnt);
                chk("mem_read_q", mem_read_q, e.mr);
                chk("mem_write_q", mem_write_q, e.mw);
                chk("mem_to_reg_q", mem_to_reg_q, e.mtr);
                chk("reg_write_q", reg_write_q, e.rw);
                if (e.known) begin
                    chk("result_q", result_q, e.res);
                    chk("store_data_q", store_data_q, e.sd);
                    chk("rd_q", rd_q, e.rd);
                    chk("branch_target_q", branch_target_q, e.tgt);
                end
            end
        end
    end

    initial begin
        stall = 0; flush = 0; in_valid = 0;
        rnd_data();
        // Reset held with random inputs: everything must read zero.
        for (int i = 0; i < 4; i++) begin
            rnd_data();
            in_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            cyc();
        end
        reset_n = 1;
        // First real instruction after release.
        instr(1, 0, 0, 1, 64'h0, 64'h0);
        alu_result = 64'h10; rd_in = 5'd5;
        cyc();
        // Taken branch then two squashed, third passes.
        instr(1, 1, 1, 0, 64'h100, 64'h8);
        cyc();
        for (int i = 0; i < 3; i++) begin
            instr(1, 0, 0, 1, 64'h0, 64'h0);
            cyc();
        end
        // Not-taken branch.
        instr(1, 1, 0, 1, 64'h200, 64'h4);
        cyc();
        // Stall during squash, then two squashed captures and a live one.
        instr(1, 1, 1, 0, 64'h300, 64'h20);
        cyc();
        for (int i = 0; i < 3; i++) begin
            instr(1, 0, 0, 1, 64'h0, 64'h0);
            stall = 1;
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            instr(1, 0, 0, 1, 64'h0, 64'h0);
            cyc();
        end
        // Flush beats stall while a taken branch is held.
        instr(1, 1, 1, 0, 64'h400, 64'h2);
        cyc();
        instr(1, 1, 1, 0, 64'h400, 64'h2);
        stall = 1;
        cyc();
        stall = 1; flush = 1;
        cyc();
        // Target wrap.
        instr(1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10);
        cyc();
        // Saturation: 20 taken branches, each followed by its squash window.
        for (int i = 0; i < 20; i++) begin
            instr(1, 1, 1, 0, {$urandom, $urandom}, {$urandom, $urandom});
            cyc();
            for (int j = 0; j < SQD; j++) begin
                instr(1, 1, 1, 1, 64'h0, 64'h0);
                cyc();
            end
        end
        // Random mix.
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            in_valid = ($urandom_range(3) != 0);
            stall    = ($urandom_range(7) == 0);
            flush    = ($urandom_range(15) == 0);
            cyc();
        end
        stall = 0; flush = 0; in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
